// File: rtl/temp_ctrl_pkg.sv
// Shared types and constants for the temperature control FSM and its sample
// confirmation stage.
package temp_ctrl_pkg;

  localparam int AGREE_W = 4;
  localparam int DWELL_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAT = 2'b01,
    ST_COOL = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    DEC_OK   = 2'b00,
    DEC_HOT  = 2'b01,
    DEC_COLD = 2'b10
  } decision_t;

  // Exactly one of greater/equal/lower must be set for a usable sample.
  function automatic logic flags_one_hot(input logic g, input logic e, input logic l);
    logic r;
    case ({g, e, l})
      3'b100, 3'b010, 3'b001: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic decision_t flags_decode(input logic g, input logic l);
    decision_t d;
    if (g)      d = DEC_HOT;
    else if (l) d = DEC_COLD;
    else        d = DEC_OK;
    return d;
  endfunction

endpackage

// File: rtl/temp_ctrl_fsm_sample_confirm.sv
// Debounce stage: validates each sample strobe, tracks the candidate decision
// and counts consecutive agreeing samples up to CONFIRM_COUNT.
module sample_confirm
  import temp_ctrl_pkg::*;
#(
  parameter int CONFIRM_COUNT = 3
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_enable,
  input  logic      i_clr_agree,
  input  logic      i_sample_valid,
  input  logic      i_temp_greater,
  input  logic      i_temp_equal,
  input  logic      i_temp_lower,
  output logic      o_confirmed,
  output decision_t o_decision,
  output logic      o_malformed
);

  localparam logic [AGREE_W-1:0] CONFIRM_Q = AGREE_W'(CONFIRM_COUNT);

  decision_t          r_candidate;
  logic [AGREE_W-1:0] r_agree_cnt;
  logic               r_malformed;

  logic      w_one_hot;
  logic      w_well_formed;
  decision_t w_decision;

  assign w_one_hot     = flags_one_hot(i_temp_greater, i_temp_equal, i_temp_lower);
  assign w_well_formed = i_sample_valid && w_one_hot;
  assign w_decision    = flags_decode(i_temp_greater, i_temp_lower);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_candidate <= DEC_OK;
      r_agree_cnt <= '0;
      r_malformed <= 1'b0;
    end else begin
      // Malformed strobes are reported even while the controller is disabled.
      r_malformed <= i_sample_valid && !w_one_hot;
      if (!i_enable) begin
        r_candidate <= DEC_OK;
        r_agree_cnt <= '0;
      end else if (i_clr_agree) begin
        r_agree_cnt <= '0;
      end else if (w_well_formed) begin
        if (w_decision == r_candidate) begin
          if (r_agree_cnt != CONFIRM_Q) r_agree_cnt <= r_agree_cnt + 1'b1;
        end else begin
          r_candidate <= w_decision;
          r_agree_cnt <= AGREE_W'(1);
        end
      end
    end
  end

  assign o_confirmed = (r_agree_cnt == CONFIRM_Q);
  assign o_decision  = r_candidate;
  assign o_malformed = r_malformed;

endmodule

// File: rtl/temp_ctrl_fsm.sv
// Heater/cooler controller: debounced decisions, minimum dwell in HEAT/COOL,
// mutually exclusive enables. Define TEMP_CTRL_TIMEOUT_EN for the sensor watchdog.
module temp_ctrl_fsm
  import temp_ctrl_pkg::*;
#(
  parameter int CONFIRM_COUNT  = 3,
  parameter int DWELL_CYCLES   = 1000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sample_valid,
  input  logic       temp_greater,
  input  logic       temp_equal,
  input  logic       temp_lower,
  output logic       heater_on,
  output logic       cooler_on,
  output logic [1:0] ctrl_state,
  output logic       flag_error,
  output logic       sensor_fault
);

  if (CONFIRM_COUNT < 1 || CONFIRM_COUNT > 15) begin : g_bad_confirm
    $error("CONFIRM_COUNT must be within 1..15");
  end
  if (DWELL_CYCLES < 1 || DWELL_CYCLES > 16777215) begin : g_bad_dwell
    $error("DWELL_CYCLES must be within 1..2^24-1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES);

  state_t             r_state;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_heater;
  logic               r_cooler;

  state_t             w_state_nxt;
  logic [DWELL_W-1:0] w_dwell_nxt;
  logic               w_confirmed;
  decision_t          w_decision;
  logic               w_malformed;
  logic               w_timeout;
  logic               w_fault;

  sample_confirm #(
    .CONFIRM_COUNT(CONFIRM_COUNT)
  ) u_confirm (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (enable),
    .i_clr_agree    (w_timeout),
    .i_sample_valid (sample_valid),
    .i_temp_greater (temp_greater),
    .i_temp_equal   (temp_equal),
    .i_temp_lower   (temp_lower),
    .o_confirmed    (w_confirmed),
    .o_decision     (w_decision),
    .o_malformed    (w_malformed)
  );

`ifdef TEMP_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd;
  logic            r_fault;
  logic            w_sample_ok;

  assign w_sample_ok = sample_valid && flags_one_hot(temp_greater, temp_equal, temp_lower);
  // A strobe in the expiring cycle counts as sensor activity, so no timeout.
  assign w_timeout   = enable && !sample_valid && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd    <= '0;
      r_fault <= 1'b0;
    end else if (!enable) begin
      r_wd <= '0;
    end else if (sample_valid) begin
      r_wd <= '0;
      if (w_sample_ok) r_fault <= 1'b0;
    end else if (w_timeout) begin
      r_wd    <= '0;
      r_fault <= 1'b1;
    end else begin
      r_wd <= r_wd + 1'b1;
    end
  end

  assign w_fault      = r_fault;
  assign sensor_fault = r_fault;
`else
  assign w_timeout    = 1'b0;
  assign w_fault      = 1'b0;
  assign sensor_fault = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_dwell_nxt = r_dwell;
    if (!enable || w_timeout) begin
      w_state_nxt = ST_IDLE;
      w_dwell_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_fault && w_confirmed) begin
            if (w_decision == DEC_COLD) begin
              w_state_nxt = ST_HEAT;
              w_dwell_nxt = DWELL_LOAD;
            end else if (w_decision == DEC_HOT) begin
              w_state_nxt = ST_COOL;
              w_dwell_nxt = DWELL_LOAD;
            end
          end
        end
        ST_HEAT: begin
          if (r_dwell != '0) w_dwell_nxt = r_dwell - 1'b1;
          else if (w_confirmed && w_decision != DEC_COLD) w_state_nxt = ST_IDLE;
        end
        ST_COOL: begin
          if (r_dwell != '0) w_dwell_nxt = r_dwell - 1'b1;
          else if (w_confirmed && w_decision != DEC_HOT) w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_dwell_nxt = '0;
        end
      endcase
    end
  end

  // Enables are registered from the next state so they track ctrl_state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_dwell  <= '0;
      r_heater <= 1'b0;
      r_cooler <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dwell  <= w_dwell_nxt;
      r_heater <= (w_state_nxt == ST_HEAT);
      r_cooler <= (w_state_nxt == ST_COOL);
    end
  end

  assign heater_on  = r_heater;
  assign cooler_on  = r_cooler;
  assign ctrl_state = r_state;
  assign flag_error = w_malformed;

endmodule

// File: tb/tb_temp_ctrl_fsm.sv
// Directed bench for temp_ctrl_fsm (CONFIRM_COUNT=3, DWELL_CYCLES=8, TIMEOUT_CYCLES=20).
module tb_temp_ctrl_fsm;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       sample_valid;
  logic       temp_greater;
  logic       temp_equal;
  logic       temp_lower;
  logic       heater_on;
  logic       cooler_on;
  logic [1:0] ctrl_state;
  logic       flag_error;
  logic       sensor_fault;

  int n_checks;
  int n_errors;

  temp_ctrl_fsm #(
    .CONFIRM_COUNT  (3),
    .DWELL_CYCLES   (8),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_valid (sample_valid),
    .temp_greater (temp_greater),
    .temp_equal   (temp_equal),
    .temp_lower   (temp_lower),
    .heater_on    (heater_on),
    .cooler_on    (cooler_on),
    .ctrl_state   (ctrl_state),
    .flag_error   (flag_error),
    .sensor_fault (sensor_fault)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang, required finish");
    $fatal(1);
  end

  typedef struct {
    logic       en, sv, g, e, l;
    logic       heat, cool;
    logic [1:0] st;
    logic       ferr;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mkv(input logic en, input logic sv, input logic g, input logic e,
                               input logic l, input logic heat, input logic cool,
                               input logic [1:0] st, input logic ferr);
    vec_t v;
    v.en = en; v.sv = sv; v.g = g; v.e = e; v.l = l;
    v.heat = heat; v.cool = cool; v.st = st; v.ferr = ferr;
    return v;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic sv, input logic g, input logic e, input logic l);
    enable = en; sample_valid = sv; temp_greater = g; temp_equal = e; temp_lower = l;
  endtask

  task automatic sample(input logic g, input logic e, input logic l);
    drive(enable, 1'b1, g, e, l);
    tick();
    drive(enable, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_tick();
    drive(enable, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // scoreboard
  task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input logic heat, input logic cool,
                            input logic [1:0] st, input logic ferr, input logic sf);
    check({nm, "_heater"}, {1'b0, heater_on}, {1'b0, heat});
    check({nm, "_cooler"}, {1'b0, cooler_on}, {1'b0, cool});
    check({nm, "_state"}, ctrl_state, st);
    check({nm, "_ferr"}, {1'b0, flag_error}, {1'b0, ferr});
    check({nm, "_fault"}, {1'b0, sensor_fault}, {1'b0, sf});
    check({nm, "_excl"}, {1'b0, heater_on & cooler_on}, 2'b00);
  endtask

  initial begin
    logic       exp_fault;
    logic [1:0] exp_st;
    logic       exp_heat;
    n_checks = 0;
    n_errors = 0;

    // stimulus table: each row is one clock, checked after its edge
    vecs[0]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    vecs[1]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    vecs[2]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    vecs[3]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    vecs[4]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    vecs[5]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    vecs[6]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    vecs[7]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    vecs[8]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    vecs[9]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    vecs[10] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    vecs[11] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    vecs[12] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    vecs[13] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    vecs[14] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    vecs[15] = mkv(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1);
    vecs[16] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;

    // IDLE -> HEAT, dwell, IDLE, COOL, malformed sample in COOL
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].en, vecs[i].sv, vecs[i].g, vecs[i].e, vecs[i].l);
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].heat, vecs[i].cool, vecs[i].st, vecs[i].ferr, 1'b0);
    end

    // reset mid-COOL
    rst = 1'b1;
    tick();
    check_outs("rst_mid_cool", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;

    // malformed sample between agreeing samples leaves the counter alone
    enable = 1'b1;
    sample(1'b0, 1'b0, 1'b1);
    check_outs("mal_l1", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    sample(1'b0, 1'b0, 1'b1);
    check_outs("mal_l2", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    sample(1'b1, 1'b0, 1'b1);
    check_outs("mal_bad", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    sample(1'b0, 1'b0, 1'b1);
    check_outs("mal_l3", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    idle_tick();
    check_outs("mal_heat", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);

    // drop enable with dwell at 5
    for (int i = 0; i < 3; i++) begin
      idle_tick();
      check_outs($sformatf("dwell_hold%0d", i), 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    end
    enable = 1'b0;
    idle_tick();
    check_outs("dis_idle", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample(1'b0, 1'b0, 1'b1);
      check_outs($sformatf("dis_ignore%0d", i), 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    end
    sample(1'b1, 1'b1, 1'b0);
    check_outs("dis_ferr", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    enable = 1'b1;
    idle_tick();
    check_outs("reen0", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    sample(1'b0, 1'b0, 1'b1);
    check_outs("reen_l", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    idle_tick();
    check_outs("reen1", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // alternating equal/lower never confirms
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) sample(1'b0, 1'b1, 1'b0);
      else            sample(1'b0, 1'b0, 1'b1);
      check_outs($sformatf("alt%0d", i), 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    end

    // two more lowers confirm COLD (last alternating sample was lower)
    sample(1'b0, 1'b0, 1'b1);
    sample(1'b0, 1'b0, 1'b1);
    check_outs("wd_pre", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    idle_tick();
    check_outs("wd_heat", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    for (int i = 2; i < 20; i++) begin
      idle_tick();
      check_outs($sformatf("wd_wait%0d", i), 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    end

`ifdef TEMP_CTRL_TIMEOUT_EN
    exp_fault = 1'b1;
    exp_st    = 2'b00;
    exp_heat  = 1'b0;
`else
    exp_fault = 1'b0;
    exp_st    = 2'b01;
    exp_heat  = 1'b1;
`endif
    idle_tick();
    check_outs("wd_expire", exp_heat, 1'b0, exp_st, 1'b0, exp_fault);
    idle_tick();
    idle_tick();
    check_outs("wd_stay", exp_heat, 1'b0, exp_st, 1'b0, exp_fault);

    sample(1'b0, 1'b0, 1'b1);
    check_outs("rec_l1", exp_heat, 1'b0, exp_st, 1'b0, 1'b0);
    sample(1'b0, 1'b0, 1'b1);
    check_outs("rec_l2", exp_heat, 1'b0, exp_st, 1'b0, 1'b0);
    sample(1'b0, 1'b0, 1'b1);
    check_outs("rec_l3", exp_heat, 1'b0, exp_st, 1'b0, 1'b0);
    idle_tick();
    check_outs("rec_heat", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/temp_ctrl_fsm.md
Name: temp_ctrl_fsm

Overview:
- Downstream stage of the temperature comparator.
- Consumes the greater/equal/lower flags (measured temperature vs. setpoint), qualified by a sample strobe issued once per I2C sensor read.
- Debounces the decision over consecutive samples, enforces minimum actuator dwell time, and drives mutually exclusive heater/cooler enables.
- Output feeds the actuator drivers directly.

Parameters:
- CONFIRM_COUNT, 3: consecutive agreeing samples needed to confirm a decision (legal range 1-15).
- DWELL_CYCLES, 1000: minimum clk cycles HEAT or COOL is held once entered (legal range 1 to 2^24-1).
- TIMEOUT_CYCLES, 100000: clk cycles without sample_valid before fault; used only with the macro.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  control enable; low forces IDLE.
- sample_valid  in  1  one-cycle strobe; flags below are valid this cycle.
- temp_greater  in  1  measured > setpoint (too hot).
- temp_equal  in  1  measured == setpoint.
- temp_lower  in  1  measured < setpoint (too cold).
- heater_on  out  1  heater enable.
- cooler_on  out  1  cooler enable.
- ctrl_state  out  2  current state: IDLE=00, HEAT=01, COOL=10.
- flag_error  out  1  one-cycle pulse on a malformed sample.
- sensor_fault  out  1  sticky timeout fault; constant 0 without the macro.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; all counters 0; candidate decision OK.
- Decision decode: greater→HOT, lower→COLD, equal→OK.
- Malformed sample: sample_valid with flags not exactly one-hot → flag_error=1 the next cycle; sample ignored; counters unchanged.
- Confirmation:
  - On a well-formed sample matching the candidate, agree counter increments and saturates at CONFIRM_COUNT.
  - On a mismatching sample, candidate is replaced and counter is set to 1.
  - "confirmed" = counter==CONFIRM_COUNT.
- Latency: the state changes at the clock edge one cycle after the edge that registers the confirming sample. heater_on/cooler_on are decoded from the state register, so they are visible 2 cycles after the sample_valid cycle.
- State machine (while enable=1):
  - IDLE→HEAT when confirmed COLD.
  - IDLE→COOL when confirmed HOT.
  - Otherwise stay in IDLE.
  - Entering HEAT or COOL loads the dwell counter with DWELL_CYCLES; it decrements each cycle to 0.
  - HEAT→IDLE when dwell==0 and confirmed decision is OK or HOT.
  - COOL→IDLE when dwell==0 and confirmed decision is OK or COLD.
  - No direct HEAT↔COOL transition; IDLE is occupied for at least 1 cycle between them.
- Outputs: heater_on=(state==HEAT), cooler_on=(state==COOL). Both asserted together is illegal in every cycle.
- Disable: enable=0 → next edge state=IDLE, dwell counter=0, agree counter=0, candidate=OK. Disable overrides dwell. Samples are ignored while disabled; flag_error is still reported.
- Priority: rst > enable=0 > timeout fault > normal transitions.
- Simultaneous events: a sample arriving in the same cycle dwell reaches 0 is counted first; the transition uses the updated confirmation on the following edge.

Optional Feature:
- Macro: TEMP_CTRL_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counts cycles while enable=1 and clears on every sample_valid.
  - On reaching TIMEOUT_CYCLES: sensor_fault=1 (sticky), state forced to IDLE, agree counter cleared.
  - While faulted, IDLE is not exited.
  - The next well-formed sample_valid clears sensor_fault and is counted as the first agreeing sample (counter=1).
- Without the macro: no watchdog logic; sensor_fault driven constant 0. The port is always present.

Decomposition:
- Package temp_ctrl_pkg holds:
  - state encoding constants IDLE/HEAT/COOL (2-bit);
  - decision codes OK/HOT/COLD (2-bit);
  - the agree-counter width (4) and dwell-counter width (24) constants.
- Sub-module sample_confirm: one-hot check, candidate register, agree counter. Outputs confirmed, decision and malformed.
- The FSM, dwell counter and optional watchdog stay in temp_ctrl_fsm.

Test Plan (CONFIRM_COUNT=3, DWELL_CYCLES=8, TIMEOUT_CYCLES=20):
- 3 lower samples from IDLE → heater_on=1 exactly 2 cycles after the 3rd strobe; ctrl_state=01; cooler_on=0.
- In HEAT, 3 greater samples within 4 cycles of entry → stays HEAT until dwell=0, then IDLE; cooler_on rises no earlier than 1 cycle later (after 3 more confirmations are already held).
- Sample with greater=1 and lower=1 → flag_error pulses 1 cycle; agree counter unchanged; state unchanged.
- Alternating lower/equal samples ×10 → never confirmed; heater_on stays 0.
- enable dropped mid-HEAT (dwell=5) → ctrl_state=00 and heater_on=0 on the next edge. rst asserted mid-COOL → all outputs 0 the next edge.
- Macro on, 20 cycles with no strobe in HEAT → sensor_fault=1, IDLE. 3 lower samples then restore HEAT; sensor_fault clears on the first of them.
